// File: rtl/rv32i_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : rv32i_pkg
//  Description : Shared RV32I constants and the fetch-queue slot record.
//  Revision    : 1.0  initial release
// ============================================================================
package rv32i_pkg;

    localparam int XLEN = 32;

    // addi x0, x0, 0 : canonical RV32I no-op
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    // One fetch-queue entry: fetch address, returned word, word-present flag
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] data;
        logic            filled;
    } slot_t;

endpackage : rv32i_pkg
`default_nettype wire

// File: rtl/instr_fetch_queue_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : instr_fetch_queue_if
//  Description : PC / instruction-memory / decode signals of the fetch queue.
//                slave  = the fetch queue itself
//                master = the surrounding PC unit, memory and decode stage
//  Revision    : 1.0  initial release
// ============================================================================
interface instr_fetch_queue_if #(
    parameter int SIZE = 32
);
    logic [SIZE-1:0] PC_Addr;
    logic            flush;
    logic            pc_stall;
    logic            imem_req;
    logic [SIZE-1:0] imem_addr;
    logic            imem_rvalid;
    logic [SIZE-1:0] imem_rdata;
    logic            inst_valid;
    logic [SIZE-1:0] inst_out;
    logic [SIZE-1:0] inst_pc;
    logic            dec_ready;

    modport slave (
        input  PC_Addr, flush, imem_rvalid, imem_rdata, dec_ready,
        output pc_stall, imem_req, imem_addr, inst_valid, inst_out, inst_pc
    );

    modport master (
        output PC_Addr, flush, imem_rvalid, imem_rdata, dec_ready,
        input  pc_stall, imem_req, imem_addr, inst_valid, inst_out, inst_pc
    );

endinterface : instr_fetch_queue_if
`default_nettype wire

// File: rtl/fetch_slot_ring.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : fetch_slot_ring
//  Description : Circular slot array with head / alloc / fill pointers.
//                alloc reserves the next slot for an issued PC, fill drops
//                returned data into the oldest unfilled slot, pop retires
//                the head, clear empties the ring (redirect).
//  Revision    : 1.0  initial release
// ============================================================================
module fetch_slot_ring
    import rv32i_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  wire logic             clk,
    input  wire logic             reset,
    input  wire logic             i_clear,
    input  wire logic             i_alloc,
    input  wire logic [XLEN-1:0]  i_alloc_pc,
    input  wire logic             i_fill,
    input  wire logic [XLEN-1:0]  i_fill_data,
    input  wire logic             i_pop,
    output slot_t                 o_head
);

    localparam int c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [XLEN-1:0]    r_pc_q   [DEPTH];
    logic [XLEN-1:0]    r_data_q [DEPTH];
    logic [DEPTH-1:0]   r_filled_q;
    logic [c_PTR_W-1:0] r_head_q;
    logic [c_PTR_W-1:0] r_alloc_q;
    logic [c_PTR_W-1:0] r_fill_q;

    // Pointers and filled flags; DEPTH is a power of two so pointers wrap for free.
    // A popped slot is marked empty; the fill write comes last since the fill
    // slot can never be the head being popped.
    always_ff @(posedge clk) begin
        if (reset || i_clear) begin
            r_head_q   <= '0;
            r_alloc_q  <= '0;
            r_fill_q   <= '0;
            r_filled_q <= '0;
        end else begin
            if (i_pop) begin
                r_filled_q[r_head_q] <= 1'b0;
                r_head_q             <= r_head_q + c_PTR_W'(1);
            end
            if (i_alloc) begin
                r_filled_q[r_alloc_q] <= 1'b0;
                r_alloc_q             <= r_alloc_q + c_PTR_W'(1);
            end
            if (i_fill) begin
                r_filled_q[r_fill_q] <= 1'b1;
                r_fill_q             <= r_fill_q + c_PTR_W'(1);
            end
        end
    end

    // Slot payload; only ever observed through a set filled flag, so no reset.
    always_ff @(posedge clk) begin
        if (i_alloc) begin
            r_pc_q[r_alloc_q] <= i_alloc_pc;
        end
        if (i_fill) begin
            r_data_q[r_fill_q] <= i_fill_data;
        end
    end

    assign o_head.pc     = r_pc_q[r_head_q];
    assign o_head.data   = r_data_q[r_head_q];
    assign o_head.filled = r_filled_q[r_head_q];

endmodule : fetch_slot_ring
`default_nettype wire

// File: rtl/instr_fetch_queue.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : instr_fetch_queue
//  Description : Issues in-order instruction reads for the PC stream, buffers
//                the returned words with their PC and hands them to decode.
//                A redirect (flush) empties the queue and arranges for every
//                still-outstanding response to be thrown away on return.
//  Revision    : 1.0  initial release
// ============================================================================
module instr_fetch_queue
    import rv32i_pkg::*;
#(
    parameter int              SIZE  = XLEN,
    parameter int              DEPTH = 4,
    parameter logic [SIZE-1:0] NOP   = NOP_INSTR
) (
    input  wire logic          clk,
    input  wire logic          reset,
    instr_fetch_queue_if.slave bus
);

    localparam int                 c_CNT_W = $clog2(DEPTH + 1);
    localparam logic [c_CNT_W-1:0] c_FULL  = c_CNT_W'(DEPTH);

    logic [c_CNT_W-1:0] r_count_q, w_count_d;   // allocated slots
    logic [c_CNT_W-1:0] r_pend_q,  w_pend_d;    // requests awaiting a response
    logic [c_CNT_W-1:0] r_disc_q,  w_disc_d;    // responses still to be dropped

    slot_t w_head;
    logic  w_inst_valid;
    logic  w_pop;
    logic  w_issue;
    logic  w_resp;
    logic  w_fill;

    // A response with nothing outstanding cannot belong to us (e.g. it was in
    // flight across a reset), so it is ignored.
    assign w_resp       = bus.imem_rvalid & (r_pend_q != '0) & ~reset;
    assign w_inst_valid = w_head.filled & (r_count_q != '0) & ~bus.flush & ~reset;
    assign w_pop        = w_inst_valid & bus.dec_ready;
    // A full queue may still issue when the head leaves in the same cycle
    assign w_issue      = ~reset & ~bus.flush
                        & ((r_count_q < c_FULL) | w_pop)
                        & (r_pend_q < c_FULL);
    // Data lands only when it is not stale and no redirect is happening now
    assign w_fill       = w_resp & (r_disc_q == '0) & ~bus.flush;

    // Next-state for the occupancy, outstanding and discard counters
    always_comb begin
        w_pend_d = r_pend_q;
        if (w_issue && !w_resp) begin
            w_pend_d = r_pend_q + c_CNT_W'(1);
        end else if (!w_issue && w_resp) begin
            w_pend_d = r_pend_q - c_CNT_W'(1);
        end

        w_count_d = r_count_q;
        if (bus.flush) begin
            w_count_d = '0;
        end else if (w_issue && !w_pop) begin
            w_count_d = r_count_q + c_CNT_W'(1);
        end else if (!w_issue && w_pop) begin
            w_count_d = r_count_q - c_CNT_W'(1);
        end

        // On a redirect every response still outstanding is stale
        w_disc_d = r_disc_q;
        if (bus.flush) begin
            w_disc_d = w_pend_d;
        end else if (w_resp && (r_disc_q != '0)) begin
            w_disc_d = r_disc_q - c_CNT_W'(1);
        end
    end

    // Counter registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count_q <= '0;
            r_pend_q  <= '0;
            r_disc_q  <= '0;
        end else begin
            r_count_q <= w_count_d;
            r_pend_q  <= w_pend_d;
            r_disc_q  <= w_disc_d;
        end
    end

    fetch_slot_ring #(
        .DEPTH (DEPTH)
    ) u_ring (
        .clk         (clk),
        .reset       (reset),
        .i_clear     (bus.flush),
        .i_alloc     (w_issue),
        .i_alloc_pc  (bus.PC_Addr),
        .i_fill      (w_fill),
        .i_fill_data (bus.imem_rdata),
        .i_pop       (w_pop),
        .o_head      (w_head)
    );

    assign bus.imem_req   = w_issue;
    assign bus.imem_addr  = bus.PC_Addr;
    assign bus.pc_stall   = ~w_issue;
    assign bus.inst_valid = w_inst_valid;
    assign bus.inst_out   = w_inst_valid ? w_head.data : NOP;
    assign bus.inst_pc    = w_inst_valid ? w_head.pc   : '0;

endmodule : instr_fetch_queue
`default_nettype wire

// File: doc/instr_fetch_queue.md
Name: instr_fetch_queue

Overview:
- Consumer side of the PC unit: takes the PC address stream, issues in-order instruction-memory reads, and buffers returned words with their PC.
- Presents buffered instructions to the decode stage over a valid/ready handshake.
- Back-pressures the PC through pc_stall.
- Discards stale and in-flight fetches when the PC is redirected by a mispredict or JALR.

Parameters:
- size, 32, address/instruction width
- DEPTH, 4, number of queue slots; power of two, ≥2
- NOP, 32'h00000013, value driven on inst_out when no valid instruction is at the head

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high; all state is cleared on the rising clk edge when high
- PC_Addr  input  size  current fetch address from the PC unit
- flush  input  1  redirect pulse (MPC or JALR taken); PC_Addr already holds the new target in the following cycle
- pc_stall  output  1  PC must hold PC_Addr this cycle
- imem_req  output  1  read request; memory always accepts it in the same cycle
- imem_addr  output  size  read address (= PC_Addr)
- imem_rvalid  input  1  read data valid; responses return in order, latency ≥1 cycle
- imem_rdata  input  size  read data
- inst_valid  output  1  head slot holds a fetched instruction
- inst_out  output  size  head instruction, or NOP when inst_valid=0
- inst_pc  output  size  PC of the head instruction, 0 when inst_valid=0
- dec_ready  input  1  decode accepts the head when inst_valid & dec_ready

Behaviour:
- State:
  - circular slot array: per slot {pc, data, filled}
  - pointers: head, alloc (next slot to allocate), fill (next slot to receive data)
  - count: allocated slots, 0..DEPTH
  - pending: issued but unanswered requests, 0..DEPTH
  - discard: responses still to drop, 0..DEPTH
- Reset: all counters, pointers and filled bits = 0; imem_req=0, pc_stall=1, inst_valid=0, inst_out=NOP, inst_pc=0.
- Issue:
  - imem_req = !reset & !flush & (count<DEPTH | pop) & (pending<DEPTH).
  - On issue: slot[alloc].pc <= PC_Addr, filled<=0, alloc++, count++, pending++.
  - pc_stall = !imem_req, combinational.
- Response (imem_rvalid):
  - pending-- always.
  - If discard>0: discard--, data dropped.
  - Else: slot[fill].data <= imem_rdata, filled<=1, fill++.
  - Data arriving on cycle N is visible on inst_out in cycle N+1.
- Pop:
  - inst_valid = slot[head].filled & count>0.
  - pop = inst_valid & dec_ready: head++, count--.
  - Issue and pop in the same cycle keep count unchanged; a full queue with pop may issue.
- Outputs inst_out and inst_pc are combinational from the head slot.
- Flush (highest priority):
  - In the next state, count=0, all filled bits=0, head=alloc=fill=0.
  - No issue in the flush cycle.
  - No pop in the flush cycle: inst_valid is forced to 0 that cycle.
  - discard <= pending_next, i.e. the pending count after this cycle's response is removed. Any rvalid in the flush cycle is itself dropped.
  - pending stays tracked, so later responses decrement both pending and discard.
- Back-to-back flushes accumulate correctly because discard always equals the remaining stale responses.
- Wrap-around: all pointers are modulo DEPTH.
- Invariant: count ≤ DEPTH, pending ≤ DEPTH, discard ≤ pending. The bench asserts all three every cycle.
- Reset mid-operation: all state is cleared; memory responses arriving after reset are ignored, because pending=0 gates responses (rvalid with pending=0 is a protocol error, flagged by assertion).
- Throughput: with 1-cycle memory and dec_ready held at 1, the block issues 1 request/cycle and delivers 1 instr/cycle after a 2-cycle fill.

Decomposition:
- Shared package (rv32i_pkg): XLEN=32, NOP_INSTR=32'h00000013, and the slot struct typedef {pc, data, filled}.
- One natural sub-module: fetch_slot_ring, which holds the slot array and the head/alloc/fill pointers with their alloc/fill/pop/clear strobes.
- The top level holds the pending/discard counters, issue and flush control.

Test Plan:
- Reset 3 cycles, then PC_Addr 0,4,8,… with 1-cycle memory and dec_ready=1 → imem_req rises on the first cycle after reset; the first inst_valid arrives 2 cycles later with inst_pc=0; then one instruction per cycle, PCs incrementing by 4.
- dec_ready=0 with DEPTH=4 → after 4 issues imem_req=0 and pc_stall=1. Raising dec_ready for one cycle pops PC 0, re-issues the same cycle, and count stays at 4.
- Memory latency 3, flush asserted while pending=3 → discard=3. The next 3 rvalid are dropped. The first inst_valid after the flush carries the new target PC (e.g. 0x100), never stale data.
- Flush on the same cycle as an rvalid with pending=2 → discard=1. Exactly one later response is dropped, and no slot is filled in the flush cycle.
- Two flushes 1 cycle apart with latency 4 → total discarded responses equal the total stale requests. Decode sees only the post-second-flush PCs.
- reset asserted mid-stream with pending=2 → the next cycle has inst_valid=0, inst_out=0x00000013, and count/pending/discard=0. Fetch restarts cleanly from PC_Addr after reset is released.
